// File: rtl/sram_arbiter_if.sv
// Display/draw requester ports plus the async SRAM pin bundle for sram_arbiter.
// The arbiter connects via the slave modport; requesters and the SRAM device use master.
interface sram_arbiter_if;
    logic        disp_req;
    logic [19:0] disp_addr;
    logic        disp_ack;
    logic [15:0] disp_rdata;
    logic        disp_rvalid;

    logic        draw_req;
    logic        draw_we;
    logic [19:0] draw_addr;
    logic [15:0] draw_wdata;
    logic [1:0]  draw_be;
    logic        draw_ack;
    logic [15:0] draw_rdata;
    logic        draw_rvalid;

    logic        CE;
    logic        UB;
    logic        LB;
    logic        OE;
    logic        WE;
    logic [19:0] ADDR;
    logic [15:0] sram_wdata;
    logic        sram_wdata_oe;
    logic [15:0] sram_rdata;

    logic        busy;

    modport slave (
        input  disp_req, disp_addr,
        output disp_ack, disp_rdata, disp_rvalid,
        input  draw_req, draw_we, draw_addr, draw_wdata, draw_be,
        output draw_ack, draw_rdata, draw_rvalid,
        output CE, UB, LB, OE, WE, ADDR, sram_wdata, sram_wdata_oe,
        input  sram_rdata,
        output busy
    );

    modport master (
        output disp_req, disp_addr,
        input  disp_ack, disp_rdata, disp_rvalid,
        output draw_req, draw_we, draw_addr, draw_wdata, draw_be,
        input  draw_ack, draw_rdata, draw_rvalid,
        input  CE, UB, LB, OE, WE, ADDR, sram_wdata, sram_wdata_oe,
        output sram_rdata,
        input  busy
    );
endinterface

// File: rtl/sram_arbiter.sv
// Display/draw arbiter onto one async SRAM, display has fixed priority; SRAM_ARB_STARVE_GUARD_EN forces a draw grant after STARVE_LIMIT display grants.
// Ack one cycle after grant, read data WAIT_CYCLES+2 cycles after grant; requesters hold req until ack.
module sram_arbiter #(
    parameter int WAIT_CYCLES  = 1,
    parameter int STARVE_LIMIT = 8
) (
    input  logic          Clk,
    input  logic          Reset,
    sram_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, RECOVER} state_t;

    localparam logic [1:0] LAST_WAIT = 2'(WAIT_CYCLES);

    if (WAIT_CYCLES < 0 || WAIT_CYCLES > 3 || STARVE_LIMIT < 1) begin : g_param_check
        $error("sram_arbiter: parameter out of range");
    end

    state_t      state_q, state_d;
    logic [1:0]  wait_q, wait_d;
    logic        owner_q, owner_d;
    logic [19:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [1:0]  be_q, be_d;
    logic        disp_ack_q, disp_ack_d, draw_ack_q, draw_ack_d;
    logic        disp_rvalid_q, disp_rvalid_d, draw_rvalid_q, draw_rvalid_d;
    logic [15:0] disp_rdata_q, disp_rdata_d, draw_rdata_q, draw_rdata_d;
    logic        grant_disp, grant_draw;

`ifdef SRAM_ARB_STARVE_GUARD_EN
    localparam int CW = $clog2(STARVE_LIMIT + 2);
    logic [CW-1:0] starve_q, starve_d;
    logic          starve_hit;

    assign starve_hit = (starve_q == CW'(STARVE_LIMIT));

    // Only display grants that actually made draw wait are counted.
    always_comb begin
        starve_d = starve_q;
        if (grant_draw) begin
            starve_d = '0;
        end else if (grant_disp && bus.draw_req) begin
            starve_d = starve_q + CW'(1);
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`endif

    always_comb begin
        grant_disp = 1'b0;
        grant_draw = 1'b0;
        if (state_q == IDLE) begin
`ifdef SRAM_ARB_STARVE_GUARD_EN
            if (bus.draw_req && (starve_hit || !bus.disp_req)) begin
                grant_draw = 1'b1;
            end else begin
                grant_disp = bus.disp_req;
            end
`else
            if (bus.disp_req) begin
                grant_disp = 1'b1;
            end else begin
                grant_draw = bus.draw_req;
            end
`endif
        end
    end

    always_comb begin
        state_d           = state_q;
        wait_d            = wait_q;
        owner_d           = owner_q;
        addr_d            = addr_q;
        wdata_d           = wdata_q;
        be_d              = be_q;
        disp_ack_d        = 1'b0;
        draw_ack_d        = 1'b0;
        disp_rvalid_d     = 1'b0;
        draw_rvalid_d     = 1'b0;
        disp_rdata_d      = disp_rdata_q;
        draw_rdata_d      = draw_rdata_q;
        bus.CE            = 1'b1;
        bus.OE            = 1'b1;
        bus.WE            = 1'b1;
        bus.UB            = 1'b1;
        bus.LB            = 1'b1;
        bus.ADDR          = '0;
        bus.sram_wdata    = '0;
        bus.sram_wdata_oe = 1'b0;

        case (state_q)
            IDLE: begin
                wait_d = '0;
                if (grant_disp) begin
                    owner_d    = 1'b0;
                    addr_d     = bus.disp_addr;
                    wdata_d    = '0;
                    be_d       = 2'b11;
                    disp_ack_d = 1'b1;
                    state_d    = READ;
                end else if (grant_draw) begin
                    owner_d    = 1'b1;
                    addr_d     = bus.draw_addr;
                    wdata_d    = bus.draw_wdata;
                    be_d       = bus.draw_be;
                    draw_ack_d = 1'b1;
                    state_d    = bus.draw_we ? WRITE : READ;
                end
            end
            READ: begin
                bus.CE   = 1'b0;
                bus.OE   = 1'b0;
                bus.UB   = 1'b0;
                bus.LB   = 1'b0;
                bus.ADDR = addr_q;
                if (wait_q == LAST_WAIT) begin
                    state_d = IDLE;
                    if (owner_q) begin
                        draw_rdata_d  = bus.sram_rdata;
                        draw_rvalid_d = 1'b1;
                    end else begin
                        disp_rdata_d  = bus.sram_rdata;
                        disp_rvalid_d = 1'b1;
                    end
                end else begin
                    wait_d = wait_q + 2'd1;
                end
            end
            WRITE: begin
                bus.CE            = 1'b0;
                bus.WE            = 1'b0;
                bus.UB            = ~be_q[1];
                bus.LB            = ~be_q[0];
                bus.ADDR          = addr_q;
                bus.sram_wdata    = wdata_q;
                bus.sram_wdata_oe = 1'b1;
                if (wait_q == LAST_WAIT) begin
                    state_d = RECOVER;
                end else begin
                    wait_d = wait_q + 2'd1;
                end
            end
            RECOVER: begin
                // WE has risen; keep address and data driven for hold time.
                bus.CE            = 1'b0;
                bus.ADDR          = addr_q;
                bus.sram_wdata    = wdata_q;
                bus.sram_wdata_oe = 1'b1;
                state_d           = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q       <= IDLE;
            wait_q        <= '0;
            owner_q       <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            be_q          <= '0;
            disp_ack_q    <= 1'b0;
            draw_ack_q    <= 1'b0;
            disp_rvalid_q <= 1'b0;
            draw_rvalid_q <= 1'b0;
            disp_rdata_q  <= '0;
            draw_rdata_q  <= '0;
        end else begin
            state_q       <= state_d;
            wait_q        <= wait_d;
            owner_q       <= owner_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            be_q          <= be_d;
            disp_ack_q    <= disp_ack_d;
            draw_ack_q    <= draw_ack_d;
            disp_rvalid_q <= disp_rvalid_d;
            draw_rvalid_q <= draw_rvalid_d;
            disp_rdata_q  <= disp_rdata_d;
            draw_rdata_q  <= draw_rdata_d;
        end
    end

    assign bus.disp_ack    = disp_ack_q;
    assign bus.draw_ack    = draw_ack_q;
    assign bus.disp_rvalid = disp_rvalid_q;
    assign bus.draw_rvalid = draw_rvalid_q;
    assign bus.disp_rdata  = disp_rdata_q;
    assign bus.draw_rdata  = draw_rdata_q;
    assign bus.busy        = (state_q != IDLE);
endmodule

// File: tb/tb_sram_arbiter.sv
// Randomized bench for sram_arbiter: transaction-level expected-cycle plan plus an SRAM device model.
// Build with SRAM_ARB_STARVE_GUARD_EN defined to exercise the starvation guard expectations.
module tb_sram_arbiter;
    localparam int W     = 1;
    localparam int LIMIT = 8;

    localparam logic [1:0] K_IDLE  = 2'd0;
    localparam logic [1:0] K_READ  = 2'd1;
    localparam logic [1:0] K_WRITE = 2'd2;
    localparam logic [1:0] K_REC   = 2'd3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sram_arbiter_if bus();

    sram_arbiter #(.WAIT_CYCLES(W), .STARVE_LIMIT(LIMIT)) dut (
        .Clk   (clk),
        .Reset (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- SRAM contents: device side and reference side
    logic [15:0] dev_mem [int unsigned];
    logic [15:0] ref_mem [int unsigned];

    function automatic logic [15:0] init_val(input logic [19:0] a);
        return a[15:0] ^ 16'h5A5A;
    endfunction

    function automatic logic [15:0] dev_rd(input logic [19:0] a);
        if (dev_mem.exists(32'(a))) return dev_mem[32'(a)];
        return init_val(a);
    endfunction

    function automatic logic [15:0] ref_rd(input logic [19:0] a);
        if (ref_mem.exists(32'(a))) return ref_mem[32'(a)];
        return init_val(a);
    endfunction

    always @(posedge clk) begin
        if (rst_n && !bus.CE && !bus.WE) begin
            logic [15:0] v;
            v = dev_rd(bus.ADDR);
            if (!bus.UB) v[15:8] = bus.sram_wdata[15:8];
            if (!bus.LB) v[7:0]  = bus.sram_wdata[7:0];
            dev_mem[32'(bus.ADDR)] = v;
        end
    end

    always @(negedge clk) bus.sram_rdata = dev_rd(bus.ADDR);

    // ---------------- reference model: per-grant plan of expected cycles
    typedef struct packed {
        logic [1:0]  kind;
        logic [19:0] addr;
        logic [15:0] wdata;
        logic [1:0]  be;
        logic        ack_d;
        logic        ack_w;
        logic        rv_d;
        logic        rv_w;
        logic [15:0] rd;
    } cyc_t;

    cyc_t        plan[$];
    cyc_t        cur;
    logic [15:0] exp_disp_rd;
    logic [15:0] exp_draw_rd;
`ifdef SRAM_ARB_STARVE_GUARD_EN
    int          starve;
`endif

    task automatic plan_read(input logic who, input logic [19:0] a);
        cyc_t c;
        for (int i = 0; i <= W; i++) begin
            c = '0;
            c.kind  = K_READ;
            c.addr  = a;
            c.ack_d = (i == 0) && !who;
            c.ack_w = (i == 0) && who;
            plan.push_back(c);
        end
        c = '0;
        c.rv_d = !who;
        c.rv_w = who;
        c.rd   = ref_rd(a);
        plan.push_back(c);
    endtask

    task automatic plan_write(input logic [19:0] a, input logic [15:0] d, input logic [1:0] be);
        cyc_t c;
        logic [15:0] v;
        for (int i = 0; i <= W; i++) begin
            c = '0;
            c.kind  = K_WRITE;
            c.addr  = a;
            c.wdata = d;
            c.be    = be;
            c.ack_w = (i == 0);
            plan.push_back(c);
        end
        c = '0;
        c.kind  = K_REC;
        c.addr  = a;
        c.wdata = d;
        plan.push_back(c);
        c = '0;
        plan.push_back(c);
        v = ref_rd(a);
        if (be[1]) v[15:8] = d[15:8];
        if (be[0]) v[7:0]  = d[7:0];
        ref_mem[32'(a)] = v;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            plan.delete();
            cur         = '0;
            exp_disp_rd = '0;
            exp_draw_rd = '0;
`ifdef SRAM_ARB_STARVE_GUARD_EN
            starve      = 0;
`endif
        end else begin
            if (plan.size() == 0) begin
                logic gd, gw;
                gd = bus.disp_req;
                gw = bus.draw_req && !bus.disp_req;
`ifdef SRAM_ARB_STARVE_GUARD_EN
                if (bus.draw_req && starve == LIMIT) begin
                    gd = 1'b0;
                    gw = 1'b1;
                end
                if (gw) starve = 0;
                else if (gd && bus.draw_req) starve++;
`endif
                if (gd) plan_read(1'b0, bus.disp_addr);
                else if (gw) begin
                    if (bus.draw_we) plan_write(bus.draw_addr, bus.draw_wdata, bus.draw_be);
                    else plan_read(1'b1, bus.draw_addr);
                end
            end
            cur = (plan.size() > 0) ? plan.pop_front() : '0;
            if (cur.rv_d) exp_disp_rd = cur.rd;
            if (cur.rv_w) exp_draw_rd = cur.rd;
        end
    end

    // ---------------- per-cycle compare against the plan
    bit chk_en = 1'b0;

    always @(negedge clk) begin
        if (chk_en) begin
            logic [4:0] es;
            logic [1:0] eul;
            case (cur.kind)
                K_READ:  begin es = 5'b00101; eul = 2'b00;      end
                K_WRITE: begin es = 5'b01011; eul = ~cur.be;    end
                K_REC:   begin es = 5'b01111; eul = 2'b11;      end
                default: begin es = 5'b11100; eul = 2'b11;      end
            endcase
            chk("strobes_CE_OE_WE_oe_busy", {bus.CE, bus.OE, bus.WE, bus.sram_wdata_oe, bus.busy}, es);
            if (cur.kind != K_REC) chk("ub_lb", {bus.UB, bus.LB}, eul);
            chk("addr", bus.ADDR, (cur.kind == K_IDLE) ? 20'h0 : cur.addr);
            if (cur.kind == K_WRITE || cur.kind == K_REC) chk("wdata", bus.sram_wdata, cur.wdata);
            chk("ack_disp_draw", {bus.disp_ack, bus.draw_ack}, {cur.ack_d, cur.ack_w});
            chk("rvalid_disp_draw", {bus.disp_rvalid, bus.draw_rvalid}, {cur.rv_d, cur.rv_w});
            chk("disp_rdata", bus.disp_rdata, exp_disp_rd);
            chk("draw_rdata", bus.draw_rdata, exp_draw_rd);
            chk("drive_while_oe_low", bus.sram_wdata_oe && !bus.OE, 1'b0);
        end
    end

    // ---------------- randomized requesters
    logic dack_s, wack_s;
    always @(negedge clk) begin
        dack_s = bus.disp_ack;
        wack_s = bus.draw_ack;
    end

    task automatic drive_random(input int ncyc);
        for (int i = 0; i < ncyc; i++) begin
            @(posedge clk);
            #1;
            if (!bus.disp_req || dack_s) begin
                bus.disp_req  = ($urandom_range(0, 99) < 45);
                bus.disp_addr = 20'($urandom_range(0, 31));
            end
            if (!bus.draw_req || wack_s) begin
                bus.draw_req   = ($urandom_range(0, 99) < 45);
                bus.draw_we    = 1'($urandom_range(0, 1));
                bus.draw_addr  = 20'($urandom_range(0, 31));
                bus.draw_wdata = 16'($urandom);
                bus.draw_be    = 2'($urandom_range(0, 3));
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int  da, dv, wa, nd, nw, na;
        bit  got;

        bus.disp_req   = 1'b0;
        bus.disp_addr  = '0;
        bus.draw_req   = 1'b0;
        bus.draw_we    = 1'b0;
        bus.draw_addr  = '0;
        bus.draw_wdata = '0;
        bus.draw_be    = '0;
        dev_mem[32'h12345] = 16'hBEEF;
        ref_mem[32'h12345] = 16'hBEEF;

        repeat (3) @(posedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_strobes", {bus.CE, bus.OE, bus.WE, bus.UB, bus.LB, bus.sram_wdata_oe}, 6'b111110);
        chk("rst_rdata", {bus.disp_rdata, bus.draw_rdata}, 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Display read of 0x12345 returning 0xBEEF.
        @(posedge clk);
        #1;
        bus.disp_req  = 1'b1;
        bus.disp_addr = 20'h12345;
        @(negedge clk);
        @(negedge clk);
        chk("A_ack_T1", bus.disp_ack, 1'b1);
        chk("A_OE_CE_T1", {bus.OE, bus.CE}, 2'b00);
        chk("A_addr_T1", bus.ADDR, 20'h12345);
        @(posedge clk);
        #1 bus.disp_req = 1'b0;
        @(negedge clk);
        chk("A_ack_T2", bus.disp_ack, 1'b0);
        chk("A_OE_CE_T2", {bus.OE, bus.CE}, 2'b00);
        @(negedge clk);
        chk("A_rvalid_T3", bus.disp_rvalid, 1'b1);
        chk("A_rdata_T3", bus.disp_rdata, 16'hBEEF);
        chk("A_busy_T3", bus.busy, 1'b0);

        // Draw write 0xA5C3 to 0x00FF0, upper byte only.
        @(posedge clk);
        #1;
        bus.draw_req   = 1'b1;
        bus.draw_we    = 1'b1;
        bus.draw_addr  = 20'h00FF0;
        bus.draw_wdata = 16'hA5C3;
        bus.draw_be    = 2'b10;
        @(negedge clk);
        @(negedge clk);
        chk("B_ack_T1", bus.draw_ack, 1'b1);
        chk("B_WE_UB_LB_oe_T1", {bus.WE, bus.UB, bus.LB, bus.sram_wdata_oe}, 4'b0011);
        @(posedge clk);
        #1 bus.draw_req = 1'b0;
        @(negedge clk);
        chk("B_WE_UB_LB_oe_T2", {bus.WE, bus.UB, bus.LB, bus.sram_wdata_oe}, 4'b0011);
        @(negedge clk);
        chk("B_recover_T3", {bus.WE, bus.CE, bus.sram_wdata_oe}, 3'b101);
        @(negedge clk);
        chk("B_idle_T4", {bus.busy, bus.sram_wdata_oe}, 2'b00);

        // Read back: upper byte new, lower byte untouched (0x0FF0 ^ 0x5A5A = 0x55AA).
        @(posedge clk);
        #1;
        bus.draw_req  = 1'b1;
        bus.draw_we   = 1'b0;
        bus.draw_addr = 20'h00FF0;
        got = 1'b0;
        for (int i = 0; i < 12 && !got; i++) begin
            logic ack_now, rv_now;
            @(negedge clk);
            ack_now = bus.draw_ack;
            rv_now  = bus.draw_rvalid;
            if (rv_now) begin
                got = 1'b1;
                chk("B_readback", bus.draw_rdata, 16'hA5AA);
            end
            if (ack_now) begin
                @(posedge clk);
                #1 bus.draw_req = 1'b0;
            end
        end
        if (!got) chk("B_readback_seen", 1'b0, 1'b1);

        // Simultaneous requests: display first, draw ack right after display rvalid.
        @(posedge clk);
        #1;
        bus.disp_req  = 1'b1;
        bus.disp_addr = 20'h5;
        bus.draw_req  = 1'b1;
        bus.draw_we   = 1'b0;
        bus.draw_addr = 20'h6;
        da = -1; dv = -1; wa = -1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.disp_ack && da < 0)    da = i;
            if (bus.disp_rvalid && dv < 0) dv = i;
            if (bus.draw_ack && wa < 0)    wa = i;
            @(posedge clk);
            #1;
            if (da >= 0) bus.disp_req = 1'b0;
            if (wa >= 0) bus.draw_req = 1'b0;
        end
        chk("C_disp_first", (da >= 0) && (da < wa), 1'b1);
        chk("C_draw_ack_after_rvalid", wa, dv + 1);

        // Both held high: starvation behaviour.
        bus.disp_req  = 1'b1;
        bus.disp_addr = 20'h7;
        bus.draw_req  = 1'b1;
        bus.draw_we   = 1'b0;
        bus.draw_addr = 20'h8;
        nd = 0; nw = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (bus.draw_ack) nw++;
            if (bus.disp_ack && nw == 0) nd++;
            if (nw > 0 || nd >= 20) break;
        end
        @(posedge clk);
        #1;
        bus.disp_req = 1'b0;
        bus.draw_req = 1'b0;
        repeat (6) @(negedge clk);
`ifdef SRAM_ARB_STARVE_GUARD_EN
        chk("D_disp_grants_before_draw", nd, LIMIT);
        chk("D_draw_granted", nw, 1);
`else
        chk("D_draw_starved", nw, 0);
        chk("D_disp_grants", nd, 20);
`endif

        drive_random(1500);
        @(posedge clk);
        #1;
        bus.disp_req = 1'b0;
        bus.draw_req = 1'b0;
        repeat (10) @(negedge clk);

        // Reset in the first WRITE cycle.
        @(posedge clk);
        #1;
        bus.draw_req   = 1'b1;
        bus.draw_we    = 1'b1;
        bus.draw_addr  = 20'hFFFF0;
        bus.draw_wdata = 16'h1234;
        bus.draw_be    = 2'b11;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (bus.draw_ack) got = 1'b1;
        end
        chk("F_write_ack_seen", got, 1'b1);
        chk("F_in_write", bus.WE, 1'b0);
        bus.draw_req = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("F_WE_CE_oe", {bus.WE, bus.CE, bus.sram_wdata_oe}, 3'b110);
        chk("F_busy_ack", {bus.busy, bus.draw_ack}, 2'b00);
        chk("F_rdata_cleared", {bus.disp_rdata, bus.draw_rdata}, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        na = 0;
        repeat (8) begin
            @(negedge clk);
            na += int'(bus.disp_ack) + int'(bus.draw_ack) + int'(bus.disp_rvalid) + int'(bus.draw_rvalid);
        end
        chk("F_no_late_ack_rvalid", na, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 1: extra SRAM access cycles beyond one (range 0-3).
REQ-002 SHALL have parameter STARVE_LIMIT, default 8: consecutive display grants before draw is forced (guard build only).
REQ-003 SHALL have port Clk  in  1  system clock, all state on rising edge.
REQ-004 SHALL have port Reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have ports disp_req in 1, disp_addr in 20: display read request and word address.
REQ-006 SHALL have ports disp_ack out 1, disp_rdata out 16, disp_rvalid out 1: grant pulse, read word, and read-valid pulse.
REQ-007 SHALL have ports draw_req in 1, draw_we in 1, draw_addr in 20, draw_wdata in 16, draw_be in 2: draw request, write flag, address, data, and byte enables (bit1 upper).
REQ-008 SHALL have ports draw_ack out 1, draw_rdata out 16, draw_rvalid out 1: draw grant pulse, read word, and read-valid pulse.
REQ-009 SHALL have ports CE, UB, LB, OE, WE out 1 each: active-low SRAM strobes.
REQ-010 SHALL have ports ADDR out 20, sram_wdata out 16, sram_wdata_oe out 1 (tristate drive enable), sram_rdata in 16: SRAM address and data.
REQ-011 SHALL have port busy out 1: high whenever state is not IDLE.

Function
REQ-012 SHALL implement states IDLE, READ, WRITE, RECOVER.
REQ-013 In IDLE, SHALL sample requests on each edge; disp_req wins over draw_req when both are high (fixed priority).
REQ-014 On grant, SHALL latch address, we, wdata, and be (display: we=0, be=11) into internal registers, then enter READ or WRITE.
REQ-015 SHALL pulse the granted requester's ack for exactly one cycle: the first cycle of READ/WRITE.
REQ-016 Requesters SHALL hold req and fields stable until ack; a req still high after ack is treated as a new request.
REQ-017 READ: CE=0, OE=0, WE=1, UB=LB=0, ADDR=latched address, held for WAIT_CYCLES+1 cycles.
REQ-018 At the final READ edge, SHALL register sram_rdata into the owner's rdata and return to IDLE.
REQ-019 SHALL pulse the owner's rvalid for one cycle: the first IDLE cycle after READ (ack at T+1 gives rvalid at T+2+WAIT_CYCLES).
REQ-020 rdata SHALL hold its value until the next read for the same requester.
REQ-021 WRITE: CE=0, WE=0, OE=1, UB=~be[1], LB=~be[0], sram_wdata_oe=1, held for WAIT_CYCLES+1 cycles.
REQ-022 After WRITE, SHALL spend one RECOVER cycle: WE=1, CE=0, with ADDR, data, and drive held, then go to IDLE.
REQ-023 A write with be=00 SHALL run the full cycle with UB=LB=1, leaving memory unchanged; it SHALL still ack.
REQ-024 A draw read (draw_we=0) SHALL follow REQ-017..REQ-020 with draw_rvalid.
REQ-025 IDLE outputs SHALL be CE=OE=WE=UB=LB=1, ADDR=0, sram_wdata_oe=0.
REQ-026 sram_wdata_oe SHALL never be 1 while OE=0.
REQ-027 Arbitration in the IDLE cycle that carries rvalid SHALL be allowed, so back-to-back reads cost WAIT_CYCLES+2 cycles each.

Reset
REQ-028 Reset low SHALL immediately force IDLE, the REQ-025 values, ack=rvalid=0, rdata=0, busy=0, and starvation counter=0.
REQ-029 A transaction in flight at reset SHALL be dropped with no later ack or rvalid.
REQ-030 Release SHALL take effect on the first rising Clk edge after Reset returns high.

Configuration
REQ-031 With SRAM_ARB_STARVE_GUARD_EN defined, SHALL count display grants made while draw_req is high.
REQ-032 When that count equals STARVE_LIMIT, draw SHALL win the next arbitration and the count SHALL clear.
REQ-033 The count SHALL also clear on any draw grant.
REQ-034 Without SRAM_ARB_STARVE_GUARD_EN, SHALL use pure fixed priority per REQ-013 and SHALL contain no counter logic.

Verification
REQ-035 Bench SHALL cover: WAIT_CYCLES=1, disp_req with addr 0x12345 at edge T, sram_rdata=0xBEEF -> disp_ack high at T+1, OE/CE low T+1..T+2, disp_rvalid=1 with 0xBEEF at T+3.
REQ-036 Bench SHALL cover: draw write addr 0x00FF0, data 0xA5C3, be=10 -> WE low 2 cycles, UB=0, LB=1, sram_wdata_oe=1 for 3 cycles, busy low at T+4.
REQ-037 Bench SHALL cover: disp_req and draw_req high together -> display granted first, draw_ack on the cycle after display's rvalid.
REQ-038 Bench SHALL cover: guard build, STARVE_LIMIT=8, both requests held high -> draw granted after exactly 8 display grants; non-guard build -> draw never granted.
REQ-039 Bench SHALL cover: Reset asserted mid-WRITE -> same-cycle WE=1, CE=1, sram_wdata_oe=0, and no ack or rvalid afterwards.
